// File: rtl/bits_gather.sv
// bits_gather: receive-side serial-to-parallel symbol deserializer.
// Collects demodulated bits LSB first into N-bit symbols and presents
// each finished symbol zero-extended to M bits, with a one-cycle strobe.
// In bypass (BPSK) mode every valid bit becomes its own symbol, placed at
// output bit BYPASS_SELECTION.
module bits_gather #(
    parameter int N                = 2,
    parameter int M                = 8,
    parameter int BYPASS_SELECTION = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bypass,
    input  logic         sym_start,
    input  logic         bit_valid,
    input  logic         I,
    output logic [M-1:0] O,
    output logic         O_valid,
    output logic         short_err
);

    localparam int CW = $clog2(N) + 1;

    // Reject parameter sets the datapath cannot represent.
    generate
        if (N < 2 || N > M || BYPASS_SELECTION < 0 || BYPASS_SELECTION >= N) begin : g_bad_params
            $error("bits_gather: illegal parameters N=%0d M=%0d BYPASS_SELECTION=%0d",
                   N, M, BYPASS_SELECTION);
        end
    endgenerate

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic [N-1:0]    sr_r;
    logic [N-1:0]    sr_nxt_s;
    logic [M-1:0]    o_nxt_s;
    logic            o_valid_nxt_s;
    logic            short_err_nxt_s;

    // Position the incoming bit lands on, and the register it lands in.
    // A sym_start always restarts the symbol at bit 0 on an empty register.
    logic [CW-1:0]   pos_s;
    logic [N-1:0]    base_s;
    logic [N-1:0]    sr_wr_s;

    // Write position and assembly-register contents including the new bit.
    always_comb begin
        pos_s   = {CW{1'b0}};
        base_s  = {N{1'b0}};
        sr_wr_s = {N{1'b0}};
        if (sym_start) begin
            pos_s  = {CW{1'b0}};
            base_s = {N{1'b0}};
        end else begin
            pos_s  = cnt_r;
            base_s = sr_r;
        end
        for (int i = 0; i < N; i++) begin
            if (CW'(i) == pos_s) begin
                sr_wr_s[i] = I;
            end else begin
                sr_wr_s[i] = base_s[i];
            end
        end
    end

    // Next-state, counter, assembly register and output decisions.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        sr_nxt_s        = sr_r;
        o_nxt_s         = O;
        o_valid_nxt_s   = 1'b0;
        short_err_nxt_s = 1'b0;

        if (bypass) begin
            // BPSK: one bit per symbol; the QPSK assembler is held idle so
            // nothing from this period leaks into a later symbol.
            state_nxt_s = HUNT;
            cnt_nxt_s   = {CW{1'b0}};
            sr_nxt_s    = {N{1'b0}};
            if (bit_valid) begin
                o_nxt_s                   = {M{1'b0}};
                o_nxt_s[BYPASS_SELECTION] = I;
                o_valid_nxt_s             = 1'b1;
            end else begin
                o_nxt_s = O;
            end
        end else if (bit_valid) begin
            case (state_r)
                HUNT: begin
                    if (sym_start) begin
                        sr_nxt_s    = sr_wr_s;
                        cnt_nxt_s   = CW'(1);
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end
                RUN: begin
                    // A sym_start on a partly filled symbol aborts it.
                    if (sym_start && (cnt_r != {CW{1'b0}})) begin
                        short_err_nxt_s = 1'b1;
                    end else begin
                        short_err_nxt_s = 1'b0;
                    end
                    if (pos_s == CW'(N - 1)) begin
                        o_nxt_s        = {M{1'b0}};
                        o_nxt_s[N-1:0] = sr_wr_s;
                        o_valid_nxt_s  = 1'b1;
                        cnt_nxt_s      = {CW{1'b0}};
                        sr_nxt_s       = {N{1'b0}};
                    end else begin
                        sr_nxt_s  = sr_wr_s;
                        cnt_nxt_s = pos_s + CW'(1);
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                    cnt_nxt_s   = {CW{1'b0}};
                    sr_nxt_s    = {N{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= HUNT;
            cnt_r     <= {CW{1'b0}};
            sr_r      <= {N{1'b0}};
            O         <= {M{1'b0}};
            O_valid   <= 1'b0;
            short_err <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            sr_r      <= sr_nxt_s;
            O         <= o_nxt_s;
            O_valid   <= o_valid_nxt_s;
            short_err <= short_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_bits_gather.sv
// tb_bits_gather: directed and randomized stimulus for bits_gather, checked
// against a queue-based reference model of the symbol assembly rules.
module tb_bits_gather;

    localparam int N   = 2;
    localparam int M   = 8;
    localparam int BYP = 1;

    logic         clk;
    logic         rst;
    logic         bypass;
    logic         sym_start;
    logic         bit_valid;
    logic         I;
    logic [M-1:0] O;
    logic         O_valid;
    logic         short_err;

    int errors = 0;
    int checks = 0;

    // Reference model state: bits collected so far for the current symbol.
    bit           q[$];
    bit           hunting;
    logic [M-1:0] exp_o;
    logic         exp_v;
    logic         exp_e;

    bits_gather #(.N(N), .M(M), .BYPASS_SELECTION(BYP)) dut (
        .clk       (clk),
        .rst       (rst),
        .bypass    (bypass),
        .sym_start (sym_start),
        .bit_valid (bit_valid),
        .I         (I),
        .O         (O),
        .O_valid   (O_valid),
        .short_err (short_err)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hunting = 1'b1;
        exp_o   = '0;
        exp_v   = 1'b0;
        exp_e   = 1'b0;
    endtask

    // Predict outputs after the coming edge from the inputs applied now.
    task automatic model_step(input logic bp, input logic s, input logic v, input logic b);
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (bp) begin
            hunting = 1'b1;
            q.delete();
            if (v) begin
                exp_o = 8'(b) << BYP;
                exp_v = 1'b1;
            end
        end else if (v) begin
            if (s) begin
                if (!hunting && q.size() != 0) exp_e = 1'b1;
                q.delete();
                hunting = 1'b0;
            end
            if (!hunting) begin
                q.push_back(b);
                if (q.size() == N) begin
                    exp_o = '0;
                    foreach (q[k]) exp_o = exp_o + (8'(q[k]) << k);
                    exp_v = 1'b1;
                    q.delete();
                end
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, and compare against the model.
    task automatic step(input logic bp, input logic s, input logic v, input logic b);
        bypass    = bp;
        sym_start = s;
        bit_valid = v;
        I         = b;
        model_step(bp, s, v, b);
        @(posedge clk);
        #1;
        check("O", 32'(O), 32'(exp_o));
        check("O_valid", 32'(O_valid), 32'(exp_v));
        check("short_err", 32'(short_err), 32'(exp_e));
    endtask

    // Pulse reset between edges; outputs must clear before any clock.
    task automatic async_rst();
        #2 rst = 1'b1;
        #1;
        check("rst_O", 32'(O), 32'h0);
        check("rst_O_valid", 32'(O_valid), 32'h0);
        check("rst_short_err", 32'(short_err), 32'h0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst       = 1'b1;
        bypass    = 1'b0;
        sym_start = 1'b0;
        bit_valid = 1'b0;
        I         = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_O", 32'(O), 32'h0);
        check("reset_O_valid", 32'(O_valid), 32'h0);
        check("reset_short_err", 32'(short_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Idle: bits without sym_start are discarded.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'(i % 2), 1'b1);
        check("idle_O", 32'(O), 32'h0);

        // QPSK nominal: 1,0 then 0,1.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("qpsk_a", 32'(O), 32'h01);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("qpsk_b", 32'(O), 32'h02);

        // Free-run wrap: 1,1,0,0,1,0 after one sym_start.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("wrap_a", 32'(O), 32'h03);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("wrap_b", 32'(O), 32'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("wrap_c", 32'(O), 32'h01);

        // Early sym_start aborts the partial symbol.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("early_err", 32'(short_err), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("early_O", 32'(O), 32'h02);

        // Bypass: one symbol per bit, sym_start ignored.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("byp_a", 32'(O), 32'h02);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("byp_b", 32'(O), 32'h00);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("byp_c", 32'(O), 32'h02);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        check("post_byp_hold", 32'(O), 32'h02);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("post_byp_sym", 32'(O), 32'h01);

        // Gaps inside a symbol give the same result as contiguous bits.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("gap_O", 32'(O), 32'h03);

        // Asynchronous reset after the first bit of a symbol.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        async_rst();
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("rst_no_strobe", 32'(O_valid), 32'h0);

        // Randomized traffic with mode changes and occasional resets.
        begin
            logic bp;
            bp = 1'b0;
            for (int n = 0; n < 4000; n++) begin
                if ($urandom_range(0, 49) == 0) bp = ~bp;
                if ($urandom_range(0, 299) == 0) async_rst();
                step(bp,
                     1'($urandom_range(0, 4) == 0),
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bits_gather.md
# bits_gather

Serial-to-parallel symbol deserializer on the receive side: collects demodulated bits, LSB first, into N-bit symbols and presents each symbol zero-extended to M bits. It mirrors the transmit-side flattener, which emits bit 0 of each symbol first, and shares its N/M/BYPASS_SELECTION parameterisation and BPSK bypass convention. It sits between the bit decision/timing-recovery stage and the symbol-to-byte packing logic.

## Interface
- N, 2: useful bits per symbol; legal range 2..M.
- M, 8: output width; bits [M-1:N] always 0.
- BYPASS_SELECTION, 1: output bit position that receives the serial bit in bypass (BPSK) mode; legal range 0..N-1.

- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- bypass  input  1  BPSK mode, one bit per symbol (high when is_bpsk).
- sym_start  input  1  marks the current valid bit as bit 0 of a symbol; ignored unless bit_valid high.
- bit_valid  input  1  I carries a new bit this cycle.
- I  input  1  serial bit.
- O  output  M  assembled symbol, zero-extended.
- O_valid  output  1  one-cycle strobe: O holds a new symbol.
- short_err  output  1  one-cycle strobe: symbol aborted by early sym_start.

## Operation
- Internal: shift/assembly register sr[N-1:0], bit counter cnt (width $clog2(N)+1, range 0..N-1), state in {HUNT, RUN}.
- Reset: state=HUNT, cnt=0, sr=0, O=0, O_valid=0, short_err=0.
- HUNT: bits discarded until bit_valid && sym_start; that bit is written to sr[0], cnt=1, state=RUN.
- RUN, bit_valid && !sym_start: bit written to sr[cnt]; cnt increments.
- RUN, bit_valid && sym_start with cnt≠0: partial symbol discarded, short_err pulses, bit written to sr[0], cnt=1; no O_valid.
- RUN, bit_valid && sym_start with cnt=0: normal start of a symbol, no error.
- Completion: when the bit written is at position N-1, O ← {zeros, sr with new bit}, O_valid pulses, cnt=0, sr cleared; state stays RUN (free-run: the next valid bit is bit 0 of the next symbol, with or without sym_start).
- bit_valid low: no state change; O holds last symbol.
- Bypass high (overrides state machine): each bit_valid cycle sets O to zero except O[BYPASS_SELECTION]=I, O_valid pulses; sym_start ignored; cnt=0, sr=0, short_err=0, state forced to HUNT.
- Bypass falling: block is in HUNT and waits for the next sym_start; nothing from bypass period merges into a QPSK symbol.
- Invalid parameters (N<2, N>M, BYPASS_SELECTION≥N): elaboration error via generate-time check.

## Timing
- Latency: O/O_valid asserted in the cycle after the rising edge that samples the N-th bit (bypass: after the sampling edge of each bit); both registered.
- short_err asserted in the cycle after the aborting sym_start edge; same cycle cannot carry O_valid.
- Back-to-back: bit_valid may be high every cycle; sustained throughput one symbol per N cycles (one per cycle in bypass).
- O_valid never high for two consecutive cycles unless bypass or N bits arrive in... (N≥2: minimum spacing N cycles in RUN).
- Async rst mid-symbol: outputs clear immediately; partial symbol lost; no strobe after release until a full symbol completes from HUNT.
- Bypass change takes effect on the same edge it is sampled; a bit sampled that edge is processed in the new mode.

## Test plan
- Reset/idle: rst pulse, bit_valid toggling with no sym_start -> O=0x00, O_valid never asserted, short_err 0.
- QPSK nominal (N=2,M=8): sym_start on first of bits 1,0 then 0,1 continuous -> O=0x01 then O=0x02, each O_valid one cycle, 1 cycle after last bit.
- Free-run wrap: one sym_start then 6 consecutive bits 1,1,0,0,1,0 -> O=0x03,0x00,0x01 at N-cycle spacing.
- Early sym_start: sym_start+bit 1, then sym_start+bit 0, bit 1 -> short_err pulse once, then O=0x02; no O_valid for aborted symbol.
- Bypass: bypass=1, bits 1,0,1 every cycle -> O=0x02,0x00,0x02 with O_valid each cycle; drop bypass, bits without sym_start -> no output until sym_start.
- Gaps and async reset: bit_valid low between bits of a symbol -> same O as contiguous; assert rst after first bit -> O=0 immediately, no strobe from the partial symbol.
